// File: rtl/lf_subtractor_pipe_27_if.sv
// Operand/result bus for lf_subtractor_pipe_27; carries ovf only when LF_SUB_SIGNED_OVF_EN is defined.
// A beat moves on a side when its valid and ready are both high at a rising clk; valid holds its payload until then.
interface lf_subtractor_pipe_27_if #(
    parameter int WIDTH = 27
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             borrow;
    logic             zero;
`ifdef LF_SUB_SIGNED_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, X, Y, bin, out_ready,
        input  in_ready, out_valid, D, borrow, zero, ovf
    );
    modport slave (
        input  in_valid, X, Y, bin, out_ready,
        output in_ready, out_valid, D, borrow, zero, ovf
    );
`else
    modport master (
        output in_valid, X, Y, bin, out_ready,
        input  in_ready, out_valid, D, borrow, zero
    );
    modport slave (
        input  in_valid, X, Y, bin, out_ready,
        output in_ready, out_valid, D, borrow, zero
    );
`endif
endinterface

// File: rtl/lf_subtractor_pipe_27.sv
// Three-stage Ladner-Fischer subtractor D = X - Y - bin with borrow/zero flags and valid/ready flow control.
// Optional signed-overflow output ovf is enabled by defining LF_SUB_SIGNED_OVF_EN.
module lf_subtractor_pipe_27 #(
    parameter int               WIDTH    = 27,
    parameter logic [WIDTH-1:0] DATA_RST = '0
) (
    input logic                    clk,
    input logic                    rst_n,
    lf_subtractor_pipe_27_if.slave bus
);
    localparam int IW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;

    // One prefix level: bits whose index has the blk bit set absorb the top node of the lower half-block.
    function automatic gp_t lf_level(input gp_t a, input int blk);
        gp_t r;
        int  j;
        r = a;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i & blk) != 0) begin
                j = (i & ~(2 * blk - 1)) + blk - 1;
                r.g[IW'(i)] = a.g[IW'(i)] | (a.p[IW'(i)] & a.g[IW'(j)]);
                r.p[IW'(i)] = a.p[IW'(i)] & a.p[IW'(j)];
            end
        end
        return r;
    endfunction

    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    always_comb begin
        ld3 = ~v3 | bus.out_ready;
        ld2 = ~v2 | ld3;
        ld1 = ~v1 | ld2;
    end

    assign bus.in_ready  = ld1;
    assign bus.out_valid = v3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ld1) v1 <= bus.in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
        end
    end

    // Stage 1: bitwise generate/propagate of X + ~Y + ~bin
    gp_t s1_gp;
    logic s1_cin;

    always_ff @(posedge clk) begin
        if (ld1 && bus.in_valid) begin
            s1_gp.g <= bus.X & ~bus.Y;
            s1_gp.p <= bus.X ^ ~bus.Y;
            s1_cin  <= ~bus.bin;
        end
    end

    // Stage 2: prefix levels with span 2, 4, 8
    gp_t s2_in_gp, s2_gp;
    logic [WIDTH-1:0] s2_p0;
    logic             s2_cin;

    always_comb begin
        s2_in_gp = lf_level(s1_gp, 1);
        s2_in_gp = lf_level(s2_in_gp, 2);
        s2_in_gp = lf_level(s2_in_gp, 4);
    end

    always_ff @(posedge clk) begin
        if (ld2 && v1) begin
            s2_gp  <= s2_in_gp;
            s2_p0  <= s1_gp.p;
            s2_cin <= s1_cin;
        end
    end

    // Stage 3: prefix levels with span 16, 32, then carries and difference
    gp_t              s3_gp;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff;
    logic             cout;

    always_comb begin
        s3_gp = lf_level(s2_gp, 8);
        s3_gp = lf_level(s3_gp, 16);
        carry = {s3_gp.g[WIDTH-2:0] | (s3_gp.p[WIDTH-2:0] & {(WIDTH-1){s2_cin}}), s2_cin};
        diff  = carry ^ s2_p0;
        cout  = s3_gp.g[WIDTH-1] | (s3_gp.p[WIDTH-1] & s2_cin);
    end

    logic [WIDTH-1:0] d_q;
    logic             borrow_q;
    logic             zero_q;

    // The flag outputs share the LSB of DATA_RST as their reset level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q      <= DATA_RST;
            borrow_q <= DATA_RST[0];
            zero_q   <= DATA_RST[0];
        end else if (ld3 && v2) begin
            d_q      <= diff;
            borrow_q <= ~cout;
            zero_q   <= ~|diff;
        end
    end

    assign bus.D      = d_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;

`ifdef LF_SUB_SIGNED_OVF_EN
    logic s1_xm, s1_ym, s2_xm, s2_ym, ovf_q;

    always_ff @(posedge clk) begin
        if (ld1 && bus.in_valid) begin
            s1_xm <= bus.X[WIDTH-1];
            s1_ym <= bus.Y[WIDTH-1];
        end
        if (ld2 && v1) begin
            s2_xm <= s1_xm;
            s2_ym <= s1_ym;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ld3 && v2) begin
            ovf_q <= (s2_xm ^ s2_ym) & (s2_xm ^ diff[WIDTH-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_lf_subtractor_pipe_27.sv
// Directed and streaming checks for lf_subtractor_pipe_27 (ovf checked when LF_SUB_SIGNED_OVF_EN is defined).
`timescale 1ns/1ps
module tb_lf_subtractor_pipe_27;
    localparam int W = 27;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lf_subtractor_pipe_27_if #(.WIDTH(W)) bus ();

    lf_subtractor_pipe_27 #(.WIDTH(W), .DATA_RST('0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Expected entries are {ovf, zero, borrow, D}.
    logic [W+2:0] exp_q[$];
    logic [W+2:0] pend;
    bit           push_en;
    bit           accepted;
    int           n_tests;
    int           n_fail;
    int           n_out;

    function automatic logic [W+2:0] pack(input logic [W-1:0] d, input logic b, input logic z,
                                          input logic o);
        return {o, z, b, d};
    endfunction

    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic b);
        logic [W:0]   full;
        logic [W-1:0] d;
        logic         o;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, b};
        d    = full[W-1:0];
        o    = (x[W-1] ^ y[W-1]) & (x[W-1] ^ d[W-1]);
        return {o, (d == '0), full[W], d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        logic [W+2:0] e;
        n_tests++;
        assert (exp_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL unexpected_output: observed D=%0h expected no result", bus.D);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("D", 32'(bus.D), 32'(e[W-1:0]));
            check("borrow", 32'(bus.borrow), 32'(e[W]));
            check("zero", 32'(bus.zero), 32'(e[W+1]));
`ifdef LF_SUB_SIGNED_OVF_EN
            check("ovf", 32'(bus.ovf), 32'(e[W+2]));
`endif
        end
        n_out++;
    endtask

    // Settle, log both transfers that the next edge will perform, then advance one clock.
    task automatic clk_step();
        #1;
        accepted = bus.in_valid && bus.in_ready;
        if (accepted && push_en) exp_q.push_back(pend);
        if (bus.out_valid && bus.out_ready) check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic b,
                         input logic [W+2:0] e);
        bus.X        = x;
        bus.Y        = y;
        bus.bin      = b;
        bus.in_valid = 1'b1;
        pend         = e;
    endtask

    task automatic drain();
        int budget;
        budget        = 20;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            clk_step();
            budget--;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic b,
                          input logic [W+2:0] e);
        drive(x, y, b, e);
        clk_step();
        check("op_accept", 32'(accepted), 32'd1);
        drain();
    endtask

    initial begin
        int           lat;
        int           sent;
        int           c;
        int           out0;
        int           stalls;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         b;

        n_tests       = 0;
        n_fail        = 0;
        n_out         = 0;
        push_en       = 1'b1;
        pend          = '0;
        accepted      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.X         = '0;
        bus.Y         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_D", 32'(bus.D), 32'd0);
        check("rst_borrow", 32'(bus.borrow), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single operation and latency, counted in edges from the accepting edge
        drive(W'(1000), W'(1), 1'b0, pack(W'(999), 1'b0, 1'b0, 1'b0));
        clk_step();
        check("single_accept", 32'(accepted), 32'd1);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            clk_step();
            lat++;
        end
        check("single_latency", 32'(lat), 32'd3);
        drain();

        // Arithmetic boundaries
        run_op(W'(0), W'(1), 1'b0, pack(27'h7FFFFFF, 1'b1, 1'b0, 1'b0));
        run_op(27'h4000000, W'(1), 1'b0, pack(27'h3FFFFFF, 1'b0, 1'b0, 1'b1));
        run_op(W'(5), W'(4), 1'b1, pack(27'h0, 1'b0, 1'b1, 1'b0));
        run_op(W'(5), W'(5), 1'b1, pack(27'h7FFFFFF, 1'b1, 1'b0, 1'b0));
        run_op(W'(0), W'(0), 1'b1, pack(27'h7FFFFFF, 1'b1, 1'b0, 1'b0));
        run_op(27'h5555555, 27'h5555555, 1'b0, pack(27'h0, 1'b0, 1'b1, 1'b0));
        run_op(27'h7FFFFFF, W'(0), 1'b0, pack(27'h7FFFFFF, 1'b0, 1'b0, 1'b0));
        run_op(W'(0), 27'h4000000, 1'b0, pack(27'h4000000, 1'b1, 1'b0, 1'b1));
        run_op(27'h7FFFFFF, 27'h7FFFFFF, 1'b1, pack(27'h7FFFFFF, 1'b1, 1'b0, 1'b0));
        run_op(27'h2000000, 27'h1234567, 1'b0, pack(27'h0DCBA99, 1'b0, 1'b0, 1'b0));

        // Back-pressure: six ops X = 10*(i+1), Y = i, consumer stalled in cycles 2..7
        sent = 0;
        c    = 1;
        while ((sent < 6 || exp_q.size() != 0) && c < 40) begin
            bus.out_ready = !(c >= 2 && c <= 7);
            if (sent < 6) begin
                x = W'(10 * (sent + 1));
                y = W'(sent);
                drive(x, y, 1'b0, model(x, y, 1'b0));
            end else begin
                bus.in_valid = 1'b0;
            end
            if (c >= 4 && c <= 7) begin
                #1;
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check("bp_D_stable", 32'(bus.D), 32'd10);
            end
            clk_step();
            if (accepted) sent++;
            c++;
        end
        check("bp_sent", 32'(sent), 32'd6);
        drain();

        // Full throughput with random operands
        out0          = n_out;
        stalls        = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            x = W'($urandom());
            y = W'($urandom());
            b = 1'($urandom_range(0, 1));
            drive(x, y, b, model(x, y, b));
            clk_step();
            if (!accepted) stalls++;
        end
        check("tp_in_stalls", 32'(stalls), 32'd0);
        check("tp_results", 32'(n_out - out0), 32'd997);
        drain();

        // Reset with two ops in flight; neither may ever appear
        push_en = 1'b0;
        drive(W'(7), W'(3), 1'b0, '0);
        clk_step();
        drive(W'(9), W'(1), 1'b1, '0);
        clk_step();
        push_en      = 1'b1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        clk_step();
        rst_n = 1'b1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_D", 32'(bus.D), 32'd0);
        check("mid_rst_borrow", 32'(bus.borrow), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) begin
            clk_step();
            check("mid_rst_quiet", 32'(bus.out_valid), 32'd0);
        end

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
